ge_sample_master: RTL
=====================

# ge_sample_master

Avalon-MM master that drives the guitar-effect register slave from a streaming sample source. It accepts one 32-bit input sample per valid/ready handshake, writes it to the effect's data register, then polls and reads the processed sample back. Each result is emitted on a valid/ready output stream. It sits between the codec-side sample stream and the effect slave, replacing CPU-driven register traffic.

## Interface
- ADDR_DATA, 5'd5: slave sample data register (write = push input, read = pop output).
- ADDR_STATUS, 5'd3: slave status register; bit4 = input-full sticky, bit3 = output-empty sticky.
- ADDR_RESET, 5'd7: slave soft-reset register.
- POLL_LIMIT, 16: maximum result-read attempts per sample before the sample is declared lost.
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  reset, asynchronous, active-low.
- soft_reset_req  in  1  one-cycle pulse; issues a write to ADDR_RESET at the next idle point.
- s_in_data  in  32  input sample.
- s_in_valid  in  1  input sample valid.
- s_in_ready  out  1  high only in IDLE with no pending soft reset.
- s_out_data  out  32  processed sample.
- s_out_valid  out  1  held until s_out_ready.
- s_out_ready  in  1  downstream accept.
- avm_address  out  5  slave address.
- avm_write, avm_read  out  1  transfer strobes; never both high.
- avm_writedata  out  32  write data.
- avm_readdata  in  32  read data; valid in the cycle after the read is accepted.
- avm_waitrequest  in  1  slave stall; strobes, address and data are held while high.
- drop_count  out  16  samples lost (input-full or poll exhaustion); saturates at 16'hFFFF.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- States: IDLE, WR_SMP, RD_DAT, WT_DAT, RD_ST, WT_ST, EMIT, SRST.
- IDLE:
  - If a soft reset is pending, go to SRST; a pending soft reset has priority over s_in_valid.
  - Else, on s_in_valid & s_in_ready, latch s_in_data, clear the poll counter, and go to WR_SMP.
- WR_SMP: avm_write=1, address ADDR_DATA, writedata = latched sample. Hold until waitrequest=0, then go to RD_DAT.
- RD_DAT: avm_read=1, address ADDR_DATA. On accept (waitrequest=0), go to WT_DAT.
- WT_DAT: capture avm_readdata into the result register, then go to RD_ST.
- RD_ST / WT_ST: read ADDR_STATUS and evaluate it in WT_ST.
  - bit4 set: the input write was rejected. Increment drop_count and go to IDLE. Nothing is emitted.
  - bit3 set: no result was available. Increment the poll counter.
    - If poll counter < POLL_LIMIT, go to RD_DAT.
    - Otherwise increment drop_count and go to IDLE.
  - Both bits clear: go to EMIT.
- EMIT: s_out_valid=1 with s_out_data = result register. On s_out_ready, go to IDLE.
- SRST: write 32'd0 to ADDR_RESET. On accept:
  - clear the pending flag and go to IDLE;
  - drop_count is not cleared.
- soft_reset_req arriving in any non-IDLE state is latched as pending and served after the current sample finishes.
- drop_count saturates at 16'hFFFF and never wraps.

## Timing
- Reset values:
  - state IDLE; avm_write/avm_read 0; avm_address 0; avm_writedata 0;
  - s_in_ready 1; s_out_valid 0; s_out_data 0; drop_count 0; busy 0; pending flag 0.
- Reset asserted mid-transfer aborts immediately: strobes drop asynchronously and the in-flight sample is discarded.
- Zero-wait-state latency, sample accept to s_out_valid, on first-poll success: 6 cycles. Sequence: WR_SMP 1, RD_DAT 1, WT_DAT 1, RD_ST 1, WT_ST 1, EMIT entry.
- Each extra poll adds 4 cycles. Each waitrequest cycle adds 1 cycle to its transfer.
- Handshake rules:
  - s_in_ready is deasserted the cycle after acceptance; exactly one sample is in flight.
  - s_out_data is stable while s_out_valid is high and s_out_ready is low.
- Outputs are registered; no combinational path from Avalon inputs to Avalon outputs.

## Test plan
- Zero-wait slave, result ready immediately: push 32'h0000_1234 with the slave returning 32'h0000_2468 and status 0. Required: s_out_data=32'h0000_2468, s_out_valid 6 cycles after accept, drop_count=0.
- Output-empty twice, then success: status bit3 set on the first two polls, clear on the third. Required: three data reads, one emit, drop_count=0, 14-cycle latency.
- Poll exhaustion: status bit3 is always set, POLL_LIMIT=16. Required: 16 data reads, no emit, drop_count=1, return to IDLE with s_in_ready=1.
- Input full and waitrequest stall: status bit4 is set, and waitrequest is held high for 3 cycles on the write. Required: address and writedata are stable for those 3 cycles, no emit, drop_count=1.
- Soft reset during a transfer: soft_reset_req pulses in WT_DAT. Required: the current sample is emitted first, then one write to address 7 with data 0, then IDLE.
- Async reset during RD_ST, plus backpressure and saturation:
  - Async reset asserted in RD_ST: all strobes are 0 within the same cycle and every output holds its reset value.
  - s_out_ready held low for 10 cycles: s_out_data is held stable throughout.
  - drop_count preset near 16'hFFFF: it stops at 16'hFFFF.

Source files
------------

// File: rtl/ge_sample_master.sv
// ge_sample_master: Avalon-MM master that pushes each stream sample into the effect slave, polls for the result and streams it out
module ge_sample_master (
  input  logic        clk,
  input  logic        reset,
  input  logic        soft_reset_req,
  input  logic [31:0] s_in_data,
  input  logic        s_in_valid,
  output logic        s_in_ready,
  output logic [31:0] s_out_data,
  output logic        s_out_valid,
  input  logic        s_out_ready,
  output logic [4:0]  avm_address,
  output logic        avm_write,
  output logic        avm_read,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic [15:0] drop_count,
  output logic        busy
);
  localparam logic [4:0] ADDR_DATA   = 5'd5;
  localparam logic [4:0] ADDR_STATUS = 5'd3;
  localparam logic [4:0] ADDR_RESET  = 5'd7;
  localparam logic [4:0] POLL_LIMIT  = 5'd16;
  typedef enum logic [2:0] {IDLE, WR_SMP, RD_DAT, WT_DAT, RD_ST, WT_ST, EMIT, SRST} state_t;
  state_t      state_q, state_d;
  logic [31:0] wdata_q, wdata_d, res_q, res_d;
  logic [4:0]  addr_q, addr_d, poll_q, poll_d, poll_inc;
  logic [15:0] drop_q, drop_d, drop_inc;
  logic        wr_q, wr_d, rd_q, rd_d, rdy_q, rdy_d, ov_q, ov_d, pend_q, pend_d;
  assign poll_inc = poll_q + 5'd1;
  assign drop_inc = drop_q + {15'd0, drop_q != 16'hFFFF};
  always_comb begin
    state_d = state_q;
    wdata_d = wdata_q;
    res_d   = res_q;
    addr_d  = addr_q;
    poll_d  = poll_q;
    drop_d  = drop_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    ov_d    = ov_q;
    pend_d  = pend_q | soft_reset_req;
    case (state_q)
      IDLE:
        if (pend_q) begin
          state_d = SRST;
          wr_d    = 1'b1;
          addr_d  = ADDR_RESET;
          wdata_d = '0;
        end else if (s_in_valid && rdy_q) begin
          state_d = WR_SMP;
          wr_d    = 1'b1;
          addr_d  = ADDR_DATA;
          wdata_d = s_in_data;
          poll_d  = '0;
        end
      WR_SMP:
        if (!avm_waitrequest) begin
          state_d = RD_DAT;
          wr_d    = 1'b0;
          rd_d    = 1'b1;
        end
      RD_DAT:
        if (!avm_waitrequest) begin
          state_d = WT_DAT;
          rd_d    = 1'b0;
        end
      WT_DAT: begin
        res_d   = avm_readdata;
        state_d = RD_ST;
        rd_d    = 1'b1;
        addr_d  = ADDR_STATUS;
      end
      RD_ST:
        if (!avm_waitrequest) begin
          state_d = WT_ST;
          rd_d    = 1'b0;
        end
      WT_ST:
        if (avm_readdata[4]) begin
          state_d = IDLE;
          drop_d  = drop_inc;
        end else if (avm_readdata[3]) begin
          poll_d  = poll_inc;
          state_d = poll_inc < POLL_LIMIT ? RD_DAT : IDLE;
          rd_d    = poll_inc < POLL_LIMIT;
          addr_d  = ADDR_DATA;
          drop_d  = poll_inc < POLL_LIMIT ? drop_q : drop_inc;
        end else begin
          state_d = EMIT;
          ov_d    = 1'b1;
        end
      EMIT:
        if (s_out_ready) begin
          state_d = IDLE;
          ov_d    = 1'b0;
        end
      SRST:
        if (!avm_waitrequest) begin
          state_d = IDLE;
          wr_d    = 1'b0;
          pend_d  = soft_reset_req;
        end
      default: state_d = IDLE;
    endcase
    // a newly arriving soft reset request closes the input immediately
    rdy_d = (state_d == IDLE) && !pend_d;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      wdata_q <= '0;
      res_q   <= '0;
      addr_q  <= '0;
      poll_q  <= '0;
      drop_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      rdy_q   <= 1'b1;
      ov_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
      res_q   <= res_d;
      addr_q  <= addr_d;
      poll_q  <= poll_d;
      drop_q  <= drop_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      rdy_q   <= rdy_d;
      ov_q    <= ov_d;
      pend_q  <= pend_d;
    end
  assign s_in_ready    = rdy_q;
  assign s_out_valid   = ov_q;
  assign s_out_data    = res_q;
  assign avm_address   = addr_q;
  assign avm_write     = wr_q;
  assign avm_read      = rd_q;
  assign avm_writedata = wdata_q;
  assign drop_count    = drop_q;
  assign busy          = state_q != IDLE;
endmodule
